sink_apb_arbiter: RTL and testbench

Round-robin arbiter that shares the single sink-side `apb_master` among `N_REQ` independent request sources, such as several sink controllers or a debug port. It accepts one transfer at a time, issues it on the master's valid/ready interface, and waits for completion. It then routes the completion back to the granted requester only. It sits in the sink clock domain between the request producers and `apb_master`. It also offers a sleep handshake so the sink domain can be quiesced.

---
 rtl/sink_apb_arbiter_pkg.sv | 13 +
 rtl/sink_apb_arbiter_if.sv | 40 ++++
 rtl/sink_apb_arbiter_rr_pick.sv | 32 +++
 rtl/sink_apb_arbiter.sv | 136 +++++++++++++
 tb/tb_sink_apb_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sink_apb_arbiter_pkg.sv
// Shared types for the sink-side APB request arbiter.
package sink_arb_pkg;

    localparam int unsigned MAX_N_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sink_apb_arbiter_if.sv
// Requester and apb_master signals seen by the sink arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface sink_apb_arbiter_if #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            i_req_valid;
    logic [N_REQ-1:0]            i_req_rd0_wr1;
    logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] i_req_wr_data;
    logic [N_REQ-1:0]            o_req_ready;
    logic [N_REQ-1:0]            o_rsp_valid;
    logic [DATA_WIDTH-1:0]       o_rsp_data;
    logic                        o_rsp_wr;
    logic                        o_valid;
    logic                        o_rd0_wr1;
    logic [ADDR_WIDTH-1:0]       o_addr;
    logic [DATA_WIDTH-1:0]       o_wr_data;
    logic                        i_ready;
    logic                        i_rd_valid;
    logic [DATA_WIDTH-1:0]       i_rd_data;
    logic                        i_sleep_req;
    logic                        o_sleep_ack;

    modport master (
        input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
        input  i_ready, i_rd_valid, i_rd_data, i_sleep_req,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_wr,
        output o_valid, o_rd0_wr1, o_addr, o_wr_data, o_sleep_ack
    );

    modport slave (
        output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
        output i_ready, i_rd_valid, i_rd_data, i_sleep_req,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_wr,
        input  o_valid, o_rd0_wr1, o_addr, o_wr_data, o_sleep_ack
    );

endinterface

// File: rtl/sink_apb_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request after last_grant, wrapping.
module rr_pick
    import sink_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sink_apb_arbiter.sv
// Round-robin arbiter sharing the sink apb_master among N_REQ requesters.
// Optional sleep handshake enabled by defining SINK_ARB_SLEEP_EN.
module sink_apb_arbiter
    import sink_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk_sink,
    input  logic                  i_rstn_sink,
    sink_apb_arbiter_if.master    bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > MAX_N_REQ) begin : g_bad_n_req
        $error("sink_apb_arbiter: N_REQ out of range");
    end

    arb_state_t            state;
    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      gnt_q;
    logic                  valid_q;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [N_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_wr_q;

    logic [N_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  sleep_block;
    logic                  grant_en;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (bus.i_req_valid),
        .last_grant (last_grant),
        .gnt        (pick_onehot),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    // Accept strobe is combinational so the requester sees it in the grant cycle.
    always_comb begin
        grant_en        = (state == IDLE) && pick_found && !sleep_block;
        bus.o_req_ready = grant_en ? pick_onehot : '0;
    end

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(N_REQ - 1);
            gnt_q       <= '0;
            valid_q     <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_wr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        state      <= ISSUE;
                        gnt_q      <= pick_idx;
                        last_grant <= pick_idx;
                        valid_q    <= 1'b1;
                        rw_q       <= bus.i_req_rd0_wr1[pick_idx];
                        addr_q     <= bus.i_req_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q    <= bus.i_req_wr_data[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Writes finish when the master is ready again; reads on read-data return.
                    if (rw_q ? bus.i_ready : bus.i_rd_valid) begin
                        state       <= RESP;
                        rsp_valid_q <= N_REQ'(1) << gnt_q;
                        rsp_data_q  <= rw_q ? '0 : bus.i_rd_data;
                        rsp_wr_q    <= rw_q;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= '0;
                    rsp_data_q  <= '0;
                    rsp_wr_q    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_rd0_wr1   = rw_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_wr_data   = wdata_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_wr    = rsp_wr_q;

`ifdef SINK_ARB_SLEEP_EN
    logic sleep_ack_q;

    assign sleep_block = bus.i_sleep_req;

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            sleep_ack_q <= 1'b0;
        end else begin
            sleep_ack_q <= (state == IDLE) && bus.i_sleep_req;
        end
    end

    assign bus.o_sleep_ack = sleep_ack_q;
`else
    logic unused_sleep_req;

    assign unused_sleep_req = bus.i_sleep_req;
    assign sleep_block      = 1'b0;
    assign bus.o_sleep_ack  = 1'b0;
`endif

endmodule

// File: tb/tb_sink_apb_arbiter.sv
// Directed bench for sink_apb_arbiter (N_REQ=2); table of transfers plus reset/sleep sequences.
module tb_sink_apb_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    sink_apb_arbiter_if #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sink_apb_arbiter #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk_sink  (clk),
        .i_rstn_sink (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  rw;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          busy;
        logic [31:0] rdata;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_data;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete transfer: grant in the IDLE cycle, issue, optional busy cycles, response.
    task automatic do_xfer(input vec_t v, input string tag);
        int g;
        g = v.exp_gnt[1] ? 1 : 0;
        @(negedge clk);
        bus.i_req_valid   = v.valid;
        bus.i_req_rd0_wr1 = v.rw;
        bus.i_req_addr    = {v.a1, v.a0};
        bus.i_req_wr_data = {v.d1, v.d0};
        bus.i_ready       = 1'b1;
        bus.i_rd_valid    = 1'b0;
        #1;
        chk({tag, " req_ready"}, 64'(bus.o_req_ready), 64'(v.exp_gnt));
        chk({tag, " idle o_valid"}, 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        bus.i_req_valid = v.valid & ~v.exp_gnt;
        bus.i_ready     = 1'b1;
        #1;
        chk({tag, " o_valid"}, 64'(bus.o_valid), 64'd1);
        chk({tag, " o_addr"}, 64'(bus.o_addr), 64'(g ? v.a1 : v.a0));
        chk({tag, " o_wr_data"}, 64'(bus.o_wr_data), 64'(g ? v.d1 : v.d0));
        chk({tag, " o_rd0_wr1"}, 64'(bus.o_rd0_wr1), 64'(v.rw[g]));
        chk({tag, " ready busy"}, 64'(bus.o_req_ready), 64'd0);
        for (int b = 0; b < v.busy; b++) begin
            @(negedge clk);
            bus.i_ready = 1'b0;
            #1;
            chk({tag, " busy rsp"}, 64'(bus.o_rsp_valid), 64'd0);
        end
        @(negedge clk);
        if (v.rw[g]) begin
            bus.i_ready = 1'b1;
        end else begin
            bus.i_ready    = 1'b0;
            bus.i_rd_valid = 1'b1;
            bus.i_rd_data  = v.rdata;
        end
        #1;
        chk({tag, " wait o_valid"}, 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        bus.i_rd_valid = 1'b0;
        bus.i_rd_data  = 32'h0;
        bus.i_ready    = 1'b1;
        #1;
        chk({tag, " rsp_valid"}, 64'(bus.o_rsp_valid), 64'(v.exp_gnt));
        chk({tag, " rsp_data"}, 64'(bus.o_rsp_data), 64'(v.exp_data));
        chk({tag, " rsp_wr"}, 64'(bus.o_rsp_wr), 64'(v.exp_wr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " o_valid"}, 64'(bus.o_valid), 64'd0);
        chk({tag, " o_addr"}, 64'(bus.o_addr), 64'd0);
        chk({tag, " o_wr_data"}, 64'(bus.o_wr_data), 64'd0);
        chk({tag, " o_rd0_wr1"}, 64'(bus.o_rd0_wr1), 64'd0);
        chk({tag, " o_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        chk({tag, " o_rsp_data"}, 64'(bus.o_rsp_data), 64'd0);
        chk({tag, " o_rsp_wr"}, 64'(bus.o_rsp_wr), 64'd0);
        chk({tag, " o_req_ready"}, 64'(bus.o_req_ready), 64'd0);
        chk({tag, " o_sleep_ack"}, 64'(bus.o_sleep_ack), 64'd0);
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;

        //            valid  rw     a0            a1            d0            d1     busy rdata         gnt    data          wr
        vecs[0] = '{2'b01, 2'b00, 32'h10,       32'h0,        32'h0,        32'h0, 0, 32'hDEADBEEF, 2'b01, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{2'b10, 2'b10, 32'h0,        32'h20,       32'h0,        32'h55, 3, 32'hBAD0BAD0, 2'b10, 32'h0,       1'b1};
        vecs[2] = '{2'b11, 2'b00, 32'h100,      32'h104,      32'h0,        32'h0, 1, 32'h11111111, 2'b01, 32'h11111111, 1'b0};
        vecs[3] = '{2'b11, 2'b01, 32'h108,      32'h10C,      32'hA5A5A5A5, 32'h0, 0, 32'h22222222, 2'b10, 32'h22222222, 1'b0};
        vecs[4] = '{2'b11, 2'b01, 32'h108,      32'h10C,      32'hA5A5A5A5, 32'h0, 2, 32'h33333333, 2'b01, 32'h0,        1'b1};
        vecs[5] = '{2'b11, 2'b00, 32'h110,      32'h114,      32'h0,        32'h0, 0, 32'h44444444, 2'b10, 32'h44444444, 1'b0};
        vecs[6] = '{2'b10, 2'b00, 32'h0,        32'h200,      32'h0,        32'h0, 0, 32'h5A5A0001, 2'b10, 32'h5A5A0001, 1'b0};
        vecs[7] = '{2'b01, 2'b01, 32'h300,      32'h0,        32'hFFFFFFFF, 32'h0, 1, 32'h0,        2'b01, 32'h0,        1'b1};
        vecs[8] = '{2'b11, 2'b11, 32'h3FC,      32'hFFFFFFFC, 32'h1,        32'h2, 0, 32'h0,        2'b10, 32'h0,        1'b1};

        rst_n             = 1'b0;
        bus.i_req_valid   = '0;
        bus.i_req_rd0_wr1 = '0;
        bus.i_req_addr    = '0;
        bus.i_req_wr_data = '0;
        bus.i_ready       = 1'b0;
        bus.i_rd_valid    = 1'b0;
        bus.i_rd_data     = '0;
        bus.i_sleep_req   = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_xfer(vecs[i], $sformatf("v%0d", i));
        end

`ifdef SINK_ARB_SLEEP_EN
        // Sleep raised while req0 is in flight with req1 pending.
        @(negedge clk);
        bus.i_req_valid   = 2'b01;
        bus.i_req_rd0_wr1 = 2'b00;
        bus.i_req_addr    = {32'h44, 32'h40};
        bus.i_ready       = 1'b1;
        #1;
        chk("slp grant0", 64'(bus.o_req_ready), 64'd1);
        @(negedge clk);
        bus.i_req_valid = 2'b10;
        bus.i_sleep_req = 1'b1;
        #1;
        chk("slp o_valid", 64'(bus.o_valid), 64'd1);
        @(negedge clk);
        bus.i_ready    = 1'b0;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_data  = 32'hCAFEF00D;
        @(negedge clk);
        bus.i_rd_valid = 1'b0;
        bus.i_ready    = 1'b1;
        #1;
        chk("slp rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
        chk("slp rsp_data", 64'(bus.o_rsp_data), 64'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("slp blocked1", 64'(bus.o_req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("slp blocked2", 64'(bus.o_req_ready), 64'd0);
        chk("slp ack", 64'(bus.o_sleep_ack), 64'd1);
        chk("slp idle o_valid", 64'(bus.o_valid), 64'd0);
        bus.i_sleep_req = 1'b0;
        #1;
        chk("slp release grant", 64'(bus.o_req_ready), 64'd2);
        @(negedge clk);
        bus.i_req_valid = 2'b00;
        bus.i_ready     = 1'b1;
        #1;
        chk("slp ack clear", 64'(bus.o_sleep_ack), 64'd0);
        chk("slp req1 o_valid", 64'(bus.o_valid), 64'd1);
        chk("slp req1 o_addr", 64'(bus.o_addr), 64'h44);
        @(negedge clk);
        bus.i_ready    = 1'b0;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_data  = 32'h0BADCAFE;
        @(negedge clk);
        bus.i_rd_valid = 1'b0;
        bus.i_ready    = 1'b1;
        #1;
        chk("slp req1 rsp", 64'(bus.o_rsp_valid), 64'd2);
        chk("slp req1 data", 64'(bus.o_rsp_data), 64'h0BADCAFE);
`else
        // Sleep request has no effect in this build.
        bus.i_sleep_req = 1'b1;
        v = '{2'b01, 2'b00, 32'h500, 32'h0, 32'h0, 32'h0, 0, 32'h76543210, 2'b01, 32'h76543210, 1'b0};
        do_xfer(v, "nosleep");
        @(negedge clk);
        #1;
        chk("nosleep ack", 64'(bus.o_sleep_ack), 64'd0);
        bus.i_sleep_req = 1'b0;
`endif

        // Reset while the arbiter is holding a request in ISSUE.
        @(negedge clk);
        bus.i_req_valid   = 2'b10;
        bus.i_req_rd0_wr1 = 2'b00;
        bus.i_req_addr    = {32'h80, 32'h0};
        #1;
        chk("rst grant", 64'(bus.o_req_ready), 64'd2);
        @(negedge clk);
        bus.i_req_valid = 2'b00;
        bus.i_ready     = 1'b0;
        #1;
        chk("rst issue o_valid", 64'(bus.o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst rsp", 64'(bus.o_rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("postrst rsp2", 64'(bus.o_rsp_valid), 64'd0);
        v = '{2'b11, 2'b00, 32'h600, 32'h604, 32'h0, 32'h0, 0, 32'h13572468, 2'b01, 32'h13572468, 1'b0};
        do_xfer(v, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
